// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: two clients share one adder; results return in acceptance order via a tag FIFO.
// Define ADDER_SHARE_ARBITER_FIXED_PRIORITY_EN for fixed priority (client 0 wins) instead of round-robin.
module adder_share_arbiter #(
    parameter int width = 4,
    parameter int depth = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*width-1:0] req_a,
    input  logic [2*width-1:0] req_b,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [2*width-1:0] rsp_data,
    output logic               a_valid,
    output logic               b_valid,
    input  logic               a_ready,
    input  logic               b_ready,
    output logic [width-1:0]   a_data,
    output logic [width-1:0]   b_data,
    input  logic               sum_valid,
    output logic               sum_ready,
    input  logic [width-1:0]   sum_data
);
    localparam int aw = (depth > 1) ? $clog2(depth) : 1;
    localparam int cw = $clog2(depth + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             a_sent_q, a_sent_d, b_sent_q, b_sent_d;
    logic [width-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
    logic             tags_q [depth];
    logic             tags_d [depth];
    logic [aw-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cw-1:0]    count_q, count_d;
    logic             win, accept, pop, full, empty, head, a_fire, b_fire;
`ifndef ADDER_SHARE_ARBITER_FIXED_PRIORITY_EN
    logic             rr_q, rr_d;
`endif

    always_comb begin
`ifdef ADDER_SHARE_ARBITER_FIXED_PRIORITY_EN
        win = ~req_valid[0];
`else
        win = (&req_valid) ? ~rr_q : req_valid[1];
        rr_d = accept ? win : rr_q;
`endif
        full = count_q == cw'(depth);
        empty = count_q == '0;
        accept = rst_n && state_q == IDLE && |req_valid && !full;
        req_ready = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
        a_valid = rst_n && state_q == ISSUE && !a_sent_q;
        b_valid = rst_n && state_q == ISSUE && !b_sent_q;
        a_fire = a_valid && a_ready;
        b_fire = b_valid && b_ready;
        a_data = a_data_q;
        b_data = b_data_q;
        a_data_d = accept ? (win ? req_a[2*width-1:width] : req_a[width-1:0]) : a_data_q;
        b_data_d = accept ? (win ? req_b[2*width-1:width] : req_b[width-1:0]) : b_data_q;
        a_sent_d = !accept && (a_sent_q || a_fire);
        b_sent_d = !accept && (b_sent_q || b_fire);
        state_d = accept ? ISSUE : (state_q == ISSUE && a_sent_d && b_sent_d) ? IDLE : state_q;
        // The FIFO head names the client owed the next adder result.
        head = tags_q[rd_ptr_q];
        sum_ready = rst_n && !empty && rsp_ready[head];
        rsp_valid = (rst_n && !empty && sum_valid) ? (head ? 2'b10 : 2'b01) : 2'b00;
        rsp_data = {2{sum_data}};
        pop = sum_valid && sum_ready;
        tags_d = tags_q;
        if (accept) tags_d[wr_ptr_q] = win;
        wr_ptr_d = accept ? ((wr_ptr_q == aw'(depth - 1)) ? '0 : wr_ptr_q + aw'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? ((rd_ptr_q == aw'(depth - 1)) ? '0 : rd_ptr_q + aw'(1)) : rd_ptr_q;
        count_d = count_q + cw'(accept) - cw'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sent_q <= 1'b0;
            b_sent_q <= 1'b0;
            a_data_q <= '0;
            b_data_q <= '0;
            tags_q <= '{default: 1'b0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
`ifndef ADDER_SHARE_ARBITER_FIXED_PRIORITY_EN
            rr_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            a_sent_q <= a_sent_d;
            b_sent_q <= b_sent_d;
            a_data_q <= a_data_d;
            b_data_q <= b_data_d;
            tags_q <= tags_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
`ifndef ADDER_SHARE_ARBITER_FIXED_PRIORITY_EN
            rr_q <= rr_d;
`endif
        end
    end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed and random stimulus against a transaction-level model;
// the bench also plays the shared adder, summing the operands it receives.
module tb_adder_share_arbiter;
    localparam int W = 4;
    localparam int D = 4;
`ifdef ADDER_SHARE_ARBITER_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2*W-1:0] req_a, req_b, rsp_data;
    logic a_valid, b_valid, a_ready, b_ready, sum_valid, sum_ready;
    logic [W-1:0] a_data, b_data, sum_data;

    int checks = 0;
    int errors = 0;
    bit issuing, sent_a, sent_b, after_rst;
    int last;
    int outq[$];
    logic [W-1:0] exp_sums[$];
    logic [W-1:0] adder_q[$];
    logic [W-1:0] cur_a, cur_b, rcv_a, rcv_b, last_lane;
    logic [1:0] last_rv;
    int acc_dut = 0, rsp_dut = 0, av_cnt = 0, bv_cnt = 0;
    int dut_grants[$];
    int a_pct = 100, b_pct = 100, s_pct = 100;
    bit spurious = 1'b0;
    int a0, r0;

    adder_share_arbiter #(.width(W), .depth(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
        .a_data(a_data), .b_data(b_data),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_adder();
        a_ready = $urandom_range(99) < a_pct;
        b_ready = $urandom_range(99) < b_pct;
        sum_valid = (adder_q.size() > 0) ? ($urandom_range(99) < s_pct) : (spurious && outq.size() == 0);
        sum_data = (adder_q.size() > 0) ? adder_q[0] : W'($urandom);
    endtask

    // Compare this cycle's outputs to the model, then advance the model past the coming edge.
    task automatic observe();
        int w;
        logic [1:0] er, ev;
        logic es;
        logic [W-1:0] lane;
        if ((req_valid & req_ready) != 2'b00) begin
            acc_dut++;
            dut_grants.push_back(int'(req_ready[1]));
        end
        if ((rsp_valid & rsp_ready) != 2'b00) rsp_dut++;
        av_cnt += int'(a_valid);
        bv_cnt += int'(b_valid);
        if (!rst_n) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_ab_valid", {a_valid, b_valid}, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_sum_ready", sum_ready, 0);
            issuing = 0; sent_a = 0; sent_b = 0; last = 1; after_rst = 1;
            outq.delete(); exp_sums.delete(); adder_q.delete();
            return;
        end
        if (after_rst) begin
            check("rst_a_data", a_data, 0);
            check("rst_b_data", b_data, 0);
            after_rst = 0;
        end
        w = (req_valid == 2'b11) ? (FIXED ? 0 : 1 - last) : int'(req_valid[1]);
        er = (!issuing && req_valid != 2'b00 && outq.size() < D) ? 2'(1 << w) : 2'b00;
        check("req_ready", req_ready, er);
        check("a_valid", a_valid, issuing && !sent_a);
        check("b_valid", b_valid, issuing && !sent_b);
        if (issuing && !sent_a) check("a_data", a_data, cur_a);
        if (issuing && !sent_b) check("b_data", b_data, cur_b);
        ev = (outq.size() > 0 && sum_valid) ? 2'(1 << outq[0]) : 2'b00;
        es = (outq.size() > 0) ? rsp_ready[outq[0]] : 1'b0;
        check("rsp_valid", rsp_valid, ev);
        check("sum_ready", sum_ready, es);
        if (sum_valid && es) begin
            lane = outq[0] ? rsp_data[2*W-1:W] : rsp_data[W-1:0];
            check("rsp_sum", lane, exp_sums[0]);
            last_lane = lane;
            last_rv = rsp_valid;
            void'(outq.pop_front());
            void'(exp_sums.pop_front());
            if (adder_q.size() > 0) void'(adder_q.pop_front());
        end
        if (issuing) begin
            if (!sent_a && a_ready) begin sent_a = 1; rcv_a = a_data; end
            if (!sent_b && b_ready) begin sent_b = 1; rcv_b = b_data; end
            if (sent_a && sent_b) begin
                issuing = 0;
                adder_q.push_back(W'(rcv_a + rcv_b));
            end
        end else if (er != 2'b00) begin
            cur_a = req_a[w*W +: W];
            cur_b = req_b[w*W +: W];
            outq.push_back(w);
            exp_sums.push_back(W'(cur_a + cur_b));
            issuing = 1; sent_a = 0; sent_b = 0; last = w;
        end
    endtask

    task automatic step();
        drive_adder();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic rand_ops();
        req_a = 2*W'($urandom);
        req_b = 2*W'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; req_a = '0; req_b = '0; rsp_ready = 2'b11;
        a_ready = 1'b0; b_ready = 1'b0; sum_valid = 1'b0; sum_data = '0;
        issuing = 0; sent_a = 0; sent_b = 0; after_rst = 0; last = 1;
        do_reset();
        // single client 0 operation: 3 + 5
        req_valid = 2'b01; req_a = 8'h03; req_b = 8'h05;
        step();
        req_valid = 2'b00;
        check("issue_a_data", a_data, 3);
        check("issue_b_data", b_data, 5);
        repeat (4) step();
        check("c0_rsp_valid", last_rv, 2'b01);
        check("c0_sum", last_lane, 8);
        // both clients continuously requesting
        do_reset();
        dut_grants.delete();
        a0 = acc_dut;
        req_valid = 2'b11;
        for (int i = 0; i < 20; i++) begin rand_ops(); step(); end
        check("rr_rate", acc_dut - a0, 10);
        for (int i = 0; i < dut_grants.size(); i++) check("rr_grant", dut_grants[i], FIXED ? 0 : i % 2);
        // fill the tag FIFO with responses blocked, then drain
        do_reset();
        rsp_ready = 2'b00;
        a0 = acc_dut; r0 = rsp_dut;
        for (int i = 0; i < 20; i++) begin rand_ops(); step(); end
        check("full_accepts", acc_dut - a0, D);
        check("full_block", req_ready, 2'b00);
        rsp_ready = 2'b11;
        for (int i = 0; i < 30; i++) begin rand_ops(); step(); end
        check("drain_rsp", rsp_dut - r0 >= D, 1);
        check("drain_resume", acc_dut - a0 > D, 1);
        // operand b stalled three cycles
        req_valid = 2'b00;
        do_reset();
        a_pct = 100; b_pct = 0;
        req_valid = 2'b01; rand_ops();
        step();
        av_cnt = 0; bv_cnt = 0; a0 = acc_dut;
        repeat (3) step();
        b_pct = 100;
        step();
        check("stall_a_cycles", av_cnt, 1);
        check("stall_b_cycles", bv_cnt, 4);
        check("stall_no_accept", acc_dut - a0, 0);
        req_valid = 2'b00;
        repeat (4) step();
        // client 1 wraparound, then a stray adder result with nothing outstanding
        do_reset();
        req_valid = 2'b10; req_a = 8'hF0; req_b = 8'h30;
        step();
        req_valid = 2'b00;
        repeat (4) step();
        check("wrap_rsp_valid", last_rv, 2'b10);
        check("wrap_sum", last_lane, 2);
        spurious = 1'b1;
        step();
        check("stray_sum_ready", sum_ready, 0);
        check("stray_rsp_valid", rsp_valid, 0);
        spurious = 1'b0;
        // reset with two operations outstanding
        do_reset();
        rsp_ready = 2'b00; req_valid = 2'b11;
        repeat (4) begin rand_ops(); step(); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        dut_grants.delete();
        repeat (2) step();
        check("post_rst_grant_seen", dut_grants.size() > 0, 1);
        if (dut_grants.size() > 0) check("post_rst_grant", dut_grants[0], 0);
        // random traffic with occasional resets
        a_pct = 60; b_pct = 60; s_pct = 70;
        for (int i = 0; i < 800; i++) begin
            req_valid = 2'($urandom);
            rsp_ready = 2'($urandom);
            spurious = $urandom_range(9) == 0;
            rst_n = $urandom_range(99) != 0;
            rand_ops();
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
